// File: rtl/uart8_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart8_transmitter
//  Description : 8-bit UART transmitter. Sends one start bit (low), eight data
//                bits LSB first and one stop bit (high) per accepted request.
//                Every serial bit is held for OVERSAMPLE ticks of clk, where
//                clk runs at OVERSAMPLE x baud. This is the same divided clock
//                the matching 16x receiver uses.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OVERSAMPLE : clk ticks per serial bit; power of two, 4..64 (default 16)
//  Build option
//    UART_TX_TWO_STOP_EN : when defined, the stop interval is two bit times
//                          (2 x OVERSAMPLE ticks). Ports and parameters are
//                          the same in both builds.
//  Ports
//    clk    in   1  tx clock, OVERSAMPLE x baud
//    rst_n  in   1  synchronous active-low reset
//    en     in   1  block enable; low aborts any frame and holds idle
//    start  in   1  transmit request, sampled while busy = 0
//    in     in   8  byte to send, latched on the accept edge
//    out    out  1  serial tx line, idle high
//    busy   out  1  frame in progress
//    done   out  1  one-tick pulse at frame completion
// ============================================================================
module uart8_transmitter #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start,
    input  logic [7:0] in,
    output logic       out,
    output logic       busy,
    output logic       done
);

    localparam int c_cnt_w = $clog2(OVERSAMPLE);

    // Elaboration guard on the oversample ratio.
    if ((OVERSAMPLE < 4) || (OVERSAMPLE > 64) ||
        ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_oversample
        $error("uart8_transmitter: OVERSAMPLE must be a power of two in 4..64");
    end

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        IDLE      = 3'd1,
        START_BIT = 3'd2,
        DATA_BITS = 3'd3,
        STOP_BIT  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic [2:0]           idx_q,   idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 out_q,   out_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic                 cnt_last;
    logic                 stop_finish;

    // Terminal count is all ones; the counter wraps to zero naturally there.
    assign cnt_last = (cnt_q == {c_cnt_w{1'b1}});

`ifdef UART_TX_TWO_STOP_EN
    // idx_q is reused in STOP_BIT to mark the second stop interval.
    assign stop_finish = cnt_last && (idx_q != 3'd0);
`else
    assign stop_finish = cnt_last;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;   // done is a single-tick pulse

        case (state_q)
            RESET: begin
                out_d   = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = 3'd0;
                shift_d = 8'h00;
                if (en) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                out_d = 1'b1;
                if (!en) begin
                    state_d = RESET;
                    busy_d  = 1'b0;
                end else if (start) begin
                    shift_d = in;
                    busy_d  = 1'b1;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = START_BIT;
                end
            end

            START_BIT: begin
                if (!en) begin
                    // Line is released by RESET on the following edge.
                    state_d = RESET;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = c_cnt_w'(cnt_q + 1'b1);
                    if (cnt_last) begin
                        out_d   = shift_q[0];
                        idx_d   = 3'd0;
                        state_d = DATA_BITS;
                    end
                end
            end

            DATA_BITS: begin
                if (!en) begin
                    state_d = RESET;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = c_cnt_w'(cnt_q + 1'b1);
                    if (cnt_last) begin
                        if (idx_q != 3'd7) begin
                            idx_d = idx_q + 3'd1;
                            out_d = shift_q[idx_q + 3'd1];
                        end else begin
                            idx_d   = 3'd0;
                            out_d   = 1'b1;
                            state_d = STOP_BIT;
                        end
                    end
                end
            end

            STOP_BIT: begin
                out_d = 1'b1;
                if (!en) begin
                    state_d = RESET;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = c_cnt_w'(cnt_q + 1'b1);
                    if (stop_finish) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_last) begin
                        // First of two stop intervals has elapsed.
                        idx_d = 3'd1;
                    end
                end
            end

            default: begin
                state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart8_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart8_transmitter
//  Description : Directed self-checking bench for uart8_transmitter. Expected
//                line levels are derived from the byte under test and the
//                frame timing (OS ticks per bit, stop length per build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart8_transmitter;

    localparam int OS = 16;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_TICKS = 2 * OS;
`else
    localparam int STOP_TICKS = OS;
`endif
    // Ticks from the accept edge until the done edge (160 or 176).
    localparam int L = 9 * OS + STOP_TICKS;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       start;
    logic [7:0] in;
    logic       out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    uart8_transmitter #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .in    (in),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and stop on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected line level j ticks after the accept edge for byte b.
    function automatic logic exp_line(input logic [7:0] b, input int j);
        logic [8:0] fr;
        fr = {b, 1'b0};
        if (j < 9 * OS) return fr[j / OS];
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; start = 1'b0; in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold t=%0d out=%b busy=%b done=%b expected 1 0 0", i, out, busy, done);
            end
        end
        // First edge after release moves RESET->IDLE, so start is not yet taken.
        rst_n = 1'b1; start = 1'b1;
        tick();
        checks++;
        if (out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release out=%b busy=%b expected 1 0", out, busy);
        end
        tick();
        checks++;
        if (out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_accept out=%b busy=%b expected 0 1", out, busy);
        end
        // Reset mid-frame wins over en.
        start = 1'b0; rst_n = 1'b0;
        tick();
        checks++;
        if (out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority out=%b busy=%b done=%b expected 1 0 0", out, busy, done);
        end
        rst_n = 1'b1;
        tick();   // RESET -> IDLE
    endtask

    task automatic test_single(input logic [7:0] b);
        logic el, eb, ed;
        int   bad;
        in = b; start = 1'b1;
        bad = 0;
        for (int i = 0; i < L + 2; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            el = (i < L) ? exp_line(b, i) : 1'b1;
            eb = (i < L);
            ed = (i == L);
            checks++;
            if (out !== el || busy !== eb || done !== ed) begin
                errors++;
                if (bad < 5)
                    $display("FAIL single_%h t=%0d out=%b busy=%b done=%b expected %b %b %b",
                             b, i, out, busy, done, el, eb, ed);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        logic [7:0] rx    [2];
        logic       stopb [2];
        logic       el, eb, ed;
        int         f, j, bad;
        bytes[0] = 8'h00; bytes[1] = 8'hFF;
        rx[0] = 8'h5A; rx[1] = 8'h5A; stopb[0] = 1'b0; stopb[1] = 1'b0;
        in = bytes[0]; start = 1'b1;
        bad = 0;
        for (int i = 0; i < 2 * L + 2; i++) begin
            tick();
            if (i == 0) in = bytes[1];
            if (i == L + 1) start = 1'b0;
            if (i <= L) begin f = 0; j = i; end
            else begin f = 1; j = i - L - 1; end
            el = (j < L) ? exp_line(bytes[f], j) : 1'b1;
            eb = (j < L);
            ed = (j == L);
            // Mid-bit sampling, as a 16x receiver would.
            if ((j % OS) == OS / 2) begin
                if (j / OS >= 1 && j / OS <= 8) rx[f][j / OS - 1] = out;
                if (j / OS == 9) stopb[f] = out;
            end
            checks++;
            if (out !== el || busy !== eb || done !== ed) begin
                errors++;
                if (bad < 5)
                    $display("FAIL b2b t=%0d out=%b busy=%b done=%b expected %b %b %b",
                             i, out, busy, done, el, eb, ed);
                bad++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rx[k] !== bytes[k] || stopb[k] !== 1'b1) begin
                errors++;
                $display("FAIL loopback_%0d rx=%h stop=%b expected %h 1", k, rx[k], stopb[k], bytes[k]);
            end
        end
    endtask

    task automatic test_ignored();
        logic [7:0] rx;
        logic       el, eb, ed;
        int         bad;
        in = 8'h81; start = 1'b1;
        rx = 8'h00; bad = 0;
        for (int i = 0; i < L + 21; i++) begin
            tick();
            if (i == 0)  start = 1'b0;
            if (i == 40) begin start = 1'b1; in = 8'h3C; end
            if (i == 41) start = 1'b0;
            if ((i % OS) == OS / 2 && i / OS >= 1 && i / OS <= 8) rx[i / OS - 1] = out;
            el = (i < L) ? exp_line(8'h81, i) : 1'b1;
            eb = (i < L);
            ed = (i == L);
            checks++;
            if (out !== el || busy !== eb || done !== ed) begin
                errors++;
                if (bad < 5)
                    $display("FAIL ignored t=%0d out=%b busy=%b done=%b expected %b %b %b",
                             i, out, busy, done, el, eb, ed);
                bad++;
            end
        end
        checks++;
        if (rx !== 8'h81) begin
            errors++;
            $display("FAIL ignored_byte rx=%h expected 81", rx);
        end
    endtask

    task automatic test_abort();
        logic el, eb, ed;
        int   bad;
        in = 8'hC3; start = 1'b1;
        bad = 0;
        // Edge 70 falls inside data bit 3 (edges 64..79).
        for (int i = 0; i < 76; i++) begin
            tick();
            if (i == 0)  start = 1'b0;
            if (i == 69) en = 1'b0;
            checks++;
            if (i < 70) begin
                if (out !== exp_line(8'hC3, i) || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    if (bad < 5) $display("FAIL abort_pre t=%0d out=%b busy=%b done=%b", i, out, busy, done);
                    bad++;
                end
            end else if (i == 70) begin
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_edge busy=%b done=%b expected 0 0", busy, done);
                end
            end else begin
                if (out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    if (bad < 5) $display("FAIL abort_post t=%0d out=%b busy=%b done=%b expected 1 0 0", i, out, busy, done);
                    bad++;
                end
            end
        end
        // Re-enable: first edge reaches IDLE, the next one accepts.
        en = 1'b1; start = 1'b1; in = 8'h5A;
        tick();
        checks++;
        if (out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reenable out=%b busy=%b expected 1 0", out, busy);
        end
        for (int i = 0; i < L + 2; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            el = (i < L) ? exp_line(8'h5A, i) : 1'b1;
            eb = (i < L);
            ed = (i == L);
            checks++;
            if (out !== el || busy !== eb || done !== ed) begin
                errors++;
                if (bad < 10)
                    $display("FAIL abort_resend t=%0d out=%b busy=%b done=%b expected %b %b %b",
                             i, out, busy, done, el, eb, ed);
                bad++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b0; in = 8'h00;
        test_reset();
        test_single(8'hA5);
        test_single(8'h55);
        test_back_to_back();
        test_ignored();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
